// File: rtl/min_weight_pkg.sv
// Shared types for the minimum-weight solution selector.
package min_weight_pkg;

  // Controller states: gather solution beats, then hold the result for the consumer.
  typedef enum logic {
    STATE__COLLECT = 1'b0,
    STATE__RESULT  = 1'b1
  } state_t;

endpackage

// File: rtl/axi_stream_if.sv
// Minimal AXI-stream bundle carrying data, valid, ready and last.
interface axi_stream_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] tdata;
  logic                  tvalid;
  logic                  tready;
  logic                  tlast;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/popcount.sv
// Counts set bits among the lowest n positions of data.
module popcount #(
  parameter int MAX_N = 8,
  parameter int CNT_W = $clog2(MAX_N + 1)
) (
  input  logic [MAX_N-1:0] data,
  input  logic [CNT_W-1:0] n,
  output logic [CNT_W-1:0] count
);

  // Sum only the bits that fall below the requested length.
  always_comb begin
    count = '0;
    for (int i = 0; i < MAX_N; i++) begin
      if (CNT_W'(i) < n) begin
        count = count + CNT_W'(data[i]);
      end
    end
  end

endmodule

// File: rtl/min_weight_select.sv
// Consumes a stream of GF(2) solution vectors and reports the lightest one
// of each set, together with its weight and the number of solutions seen.
module min_weight_select
  import min_weight_pkg::*;
#(
  parameter int MAX_VARS       = 16,
  parameter int AXI_DATA_WIDTH = 8,
  parameter int SOL_CNT_W      = 16,
  parameter int MAX_VARS_W     = (MAX_VARS <= 1) ? 1 : $clog2(MAX_VARS + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [MAX_VARS_W-1:0] vars,
  axi_stream_if.slave           solution_stream,
  output logic                  result_valid,
  input  logic                  result_ready,
  output logic [MAX_VARS_W-1:0] min_weight,
  output logic [MAX_VARS-1:0]   min_solution,
  output logic [SOL_CNT_W-1:0]  solution_count,
  output logic                  framing_error
);

  localparam int PC_W = $clog2(AXI_DATA_WIDTH + 1);

  state_t                  state, state_next;
  logic                    tready;
  logic [MAX_VARS_W-1:0]   beats;
  logic [MAX_VARS_W-1:0]   beat_idx;
  logic [31:0]             base_bits;
  logic [31:0]             rem_bits;
  logic [PC_W-1:0]         beat_n;
  logic [PC_W-1:0]         beat_count;
  logic [AXI_DATA_WIDTH-1:0] beat_masked;
  logic [MAX_VARS-1:0]     asm_vec;
  logic [MAX_VARS-1:0]     cand_vec;
  logic [MAX_VARS_W-1:0]   weight_acc;
  logic [MAX_VARS_W-1:0]   cand_weight;
  logic                    accept;
  logic                    last_beat;
  logic                    sol_end;
  logic                    handshake;

  assign solution_stream.tready = tready;

  // Beats per solution and number of meaningful bits in the current beat.
  always_comb begin
    beats = MAX_VARS_W'(1);
    if (vars != '0) begin
      beats = MAX_VARS_W'((32'(vars) + 32'(AXI_DATA_WIDTH) - 32'd1) / 32'(AXI_DATA_WIDTH));
    end
    base_bits = 32'(beat_idx) * 32'(AXI_DATA_WIDTH);
    rem_bits  = 32'd0;
    if (32'(vars) > base_bits) begin
      rem_bits = 32'(vars) - base_bits;
    end
    beat_n = (rem_bits >= 32'(AXI_DATA_WIDTH)) ? PC_W'(AXI_DATA_WIDTH) : PC_W'(rem_bits);
  end

  // Bits at or beyond the vector length are forced to zero before use.
  for (genvar gi = 0; gi < AXI_DATA_WIDTH; gi++) begin : g_mask
    assign beat_masked[gi] = solution_stream.tdata[gi] & (PC_W'(gi) < beat_n);
  end

  popcount #(
    .MAX_N (AXI_DATA_WIDTH),
    .CNT_W (PC_W)
  ) u_popcount (
    .data  (beat_masked),
    .n     (beat_n),
    .count (beat_count)
  );

  // Candidate vector: assembled slices with the current beat merged at its slot.
  for (genvar gi = 0; gi < MAX_VARS; gi++) begin : g_cand
    localparam int SLICE  = gi / AXI_DATA_WIDTH;
    localparam int OFFSET = gi % AXI_DATA_WIDTH;
    assign cand_vec[gi] = (beat_idx == MAX_VARS_W'(SLICE)) ? beat_masked[OFFSET] : asm_vec[gi];
  end

  assign cand_weight = weight_acc + MAX_VARS_W'(beat_count);
  assign accept      = tready && solution_stream.tvalid;
  assign last_beat   = (beat_idx == beats - MAX_VARS_W'(1));
  assign sol_end     = accept && (last_beat || solution_stream.tlast);
  assign handshake   = result_valid && result_ready;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= STATE__COLLECT;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and handshake outputs; tready depends on state alone.
  always_comb begin
    state_next   = state;
    tready       = 1'b0;
    result_valid = 1'b0;
    case (state)
      STATE__COLLECT: begin
        tready = 1'b1;
        if (solution_stream.tvalid && solution_stream.tlast) begin
          state_next = STATE__RESULT;
        end
      end
      STATE__RESULT: begin
        result_valid = 1'b1;
        if (result_ready) begin
          state_next = STATE__COLLECT;
        end
      end
      default: state_next = STATE__COLLECT;
    endcase
  end

  // Accumulate beats, keep the lightest solution, clear on result handoff.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_idx       <= '0;
      weight_acc     <= '0;
      asm_vec        <= '0;
      min_weight     <= '0;
      min_solution   <= '0;
      solution_count <= '0;
      framing_error  <= 1'b0;
    end else if (handshake) begin
      beat_idx       <= '0;
      min_weight     <= '0;
      min_solution   <= '0;
      solution_count <= '0;
      framing_error  <= 1'b0;
    end else if (accept) begin
      if (sol_end) begin
        beat_idx   <= '0;
        weight_acc <= '0;
        asm_vec    <= '0;
        // Solution count is zero only before the first solution of a set.
        if ((solution_count == '0) || (cand_weight < min_weight)) begin
          min_weight   <= cand_weight;
          min_solution <= cand_vec;
        end
        if (solution_count != '1) begin
          solution_count <= solution_count + SOL_CNT_W'(1);
        end
        if (solution_stream.tlast && !last_beat) begin
          framing_error <= 1'b1;
        end
      end else begin
        beat_idx   <= beat_idx + MAX_VARS_W'(1);
        weight_acc <= cand_weight;
        asm_vec    <= cand_vec;
      end
    end
  end

endmodule

// File: doc/min_weight_select.md
# min_weight_select

Streaming consumer that sits directly downstream of `enumerate_solutions`. It accepts the AXI-stream of GF(2) solution vectors and computes the Hamming weight of each vector. It keeps the lightest solution seen, and at the end of a solution set it presents that solution, its weight and the set's solution count on a valid/ready result port. This is the stage that turns "all button-press combinations" into "minimum presses".

## Interface
Parameters:
- `MAX_VARS`, 16: maximum solution vector length in bits.
- `AXI_DATA_WIDTH`, 8: width of `tdata` in bits.
- `SOL_CNT_W`, 16: width of the solution counter.
- `MAX_VARS_W`, `$clog2(MAX_VARS+1)` (1 if `MAX_VARS<=1`): width of the length and weight fields.

Ports:
- `clk`  in  1  clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `vars`  in  `MAX_VARS_W`  vector length of the current set; stable for the whole set.
- `solution_stream`  `axi_stream_if.slave`  `AXI_DATA_WIDTH`  solution beats (`tdata`, `tvalid`, `tready`, `tlast`).
- `result_valid`  out  1  result available.
- `result_ready`  in  1  result consumed.
- `min_weight`  out  `MAX_VARS_W`  weight of the lightest solution.
- `min_solution`  out  `MAX_VARS`  lightest solution vector; bits at and above `vars` are 0.
- `solution_count`  out  `SOL_CNT_W`  number of solutions in the set, saturating.
- `framing_error`  out  1  `tlast` arrived on a beat that was not the final beat of a solution.

## Operation
- Framing:
  - One solution occupies `BEATS = max(1, ceil(vars/AXI_DATA_WIDTH))` beats.
  - Beat k carries vector bits `[k*AXI_DATA_WIDTH +: AXI_DATA_WIDTH]`.
  - `tlast` is asserted on the final beat of the final solution of the set.
- Masking: bit positions `>= vars` are ignored for weight and stored as 0.
- States: `STATE__COLLECT` and `STATE__RESULT`.
- COLLECT:
  - `tready=1`.
  - Each accepted beat adds popcount(masked beat) to `weight_acc` and writes the masked beat into the assembly register at slice `beat_idx`.
  - `beat_idx` increments and wraps to 0 after `BEATS-1`.
- Solution end: occurs on an accepted beat with `beat_idx==BEATS-1`, or on any accepted beat carrying `tlast`. On that beat:
  - Candidate weight is `weight_acc` plus this beat's popcount.
  - The candidate replaces the best if it is the first solution of the set or strictly lighter. Ties keep the earlier solution.
  - `solution_count` increments, saturating at all-ones.
  - `weight_acc` and the assembly register clear.
- Partial solution: `tlast` with `beat_idx != BEATS-1` sets `framing_error`. The partial vector is still compared as-is.
- Transition COLLECT->RESULT: on the accepted `tlast` beat.
- RESULT:
  - `tready=0` and `result_valid=1`.
  - All result outputs are held stable until `result_ready`.
  - On `result_valid && result_ready`: clear best, `solution_count`, `framing_error` and `beat_idx`, then go to COLLECT.
- `vars=0`: `BEATS=1`, every weight is 0, `min_solution=0`.
- Reset (asserted at any time, including mid-solution or mid-RESULT):
  - State returns to COLLECT.
  - Every output register clears to 0: `result_valid`, `min_weight`, `min_solution`, `solution_count`, `framing_error`.
  - Partial accumulation is discarded.

## Timing
- Throughput is one beat per cycle in COLLECT, with no bubble between solutions or between sets apart from the RESULT cycles.
- `tready` is a function of state only; it has no combinational path from `tvalid`.
- A beat transfers on a clock edge where `tvalid && tready`.
- Latency: `result_valid` rises on the edge that accepts the `tlast` beat, so outputs are visible the following cycle.
- A set needs at least one RESULT cycle; that cycle is the handshake cycle if `result_ready` is already high.
- `result_ready` arriving in COLLECT is ignored.
- `result_valid` never drops without a handshake.
- Weight arithmetic is `MAX_VARS_W` wide and cannot overflow, since the sum is bounded by `vars`.

## Structure
- Package `min_weight_pkg`: `state_t` enum.
- `BEATS` and the per-beat valid-bit count are computed locally from `vars`.
- Sub-module: reuse the existing `popcount` (`MAX_N=AXI_DATA_WIDTH`, with `n` set to the valid bits in the current beat) for the per-beat weight.
- No other sub-modules.

## Test plan
All scenarios use `AXI_DATA_WIDTH=8` and `MAX_VARS=10`.
- Single solution: `vars=3`, one beat 0x05 with `tlast` -> `min_weight=2`, `min_solution=0x005`, `solution_count=1`, `framing_error=0`.
- Several solutions: `vars=4`, beats 0x0F, 0x03, 0x05, 0x08 (`tlast` on 0x08) -> `min_weight=1`, `min_solution=0x008`, `solution_count=4`.
- Tie and masking: `vars=4`, beats 0xF3 then 0x0C with `tlast`.
  - Upper nibble is masked, so both weigh 2.
  - Result: `min_solution=0x003`, `min_weight=2`.
- Two-beat solutions: `vars=10`.
  - Solution A: beats 0xFF, 0xFF -> weight 10.
  - Solution B: beats 0x01, 0x00 with `tlast` -> weight 1.
  - Result: `min_solution=0x001`, `min_weight=1`, `solution_count=2`.
- Backpressure: hold `result_ready=0` for 5 cycles while upstream holds `tvalid=1`.
  - `tready` stays 0 and outputs stay stable.
  - After the handshake, the next set's first beat is accepted the following cycle and `solution_count` restarts at 0.
- Framing and reset, `vars=10`:
  - `tlast` on the first beat (0x03) -> `framing_error=1`, `min_weight=2`.
  - Separately, pull `rst_n` low after the first beat of a two-beat solution -> all outputs 0 immediately.
  - A following set of 0x01, 0x00 with `tlast` -> `min_weight=1`, `solution_count=1`.
